// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one shift-left and trial-subtract per
// clock, one quotient bit resolved per cycle. Shares the start/busy/done
// handshake with the shift-add multiplier.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH:0]    a_q, a_d;      // partial remainder, one guard bit
  logic [WIDTH-1:0]  q_q, q_d;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]  m_q, m_d;      // captured divisor
  logic [CntW-1:0]   cnt_q, cnt_d;  // quotient bits still to resolve
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH+1:0]  trial;
  logic [WIDTH:0]    a_next;
  logic [WIDTH-1:0]  q_next;

  // One restoring step: shift {A,Q} left, try A - M, keep it if non-negative.
  always_comb begin
    trial  = {a_q, q_q[WIDTH-1]} - {2'b00, m_q};
    a_next = trial[WIDTH+1] ? {a_q[WIDTH-1:0], q_q[WIDTH-1]} : trial[WIDTH:0];
    q_next = {q_q[WIDTH-2:0], ~trial[WIDTH+1]};
  end

  // Next-state and datapath update; every register holds by default.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            // Divide-by-zero resolves immediately without iterating.
            state_d = StDone;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = StRun;
            a_d     = '0;
            q_d     = dividend;
            m_d     = divisor;
            cnt_d   = CntW'(WIDTH);
          end
        end
      end
      StRun: begin
        a_d   = a_next;
        q_d   = q_next;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
          quo_d   = q_next;
          rem_d   = a_next[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Handshake and result outputs.
  always_comb begin
    busy        = (state_q != StIdle);
    done        = (state_q == StDone);
    quotient    = quo_q;
    remainder   = rem_q;
    div_by_zero = dbz_q;
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8): directed cases with
// literal expectations plus a random sweep against an arithmetic model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int seen_dones = 0;

  // Model state: timestamps of the current operation and its result.
  int           m_edge = 0;
  bit           m_active = 1'b0;
  int           m_acc_e = 0;
  int           m_done_e = 0;
  int           m_accepts = 0;
  int           m_exp_dones = 0;
  logic [W-1:0] m_pq, m_pr;
  logic         m_pdbz;
  logic [W-1:0] e_q = '0;
  logic [W-1:0] e_r = '0;
  logic         e_dbz = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: acceptance by timing rules, results by plain / and %.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_active = 1'b0;
        e_q      = '0;
        e_r      = '0;
        e_dbz    = 1'b0;
      end else begin
        m_edge++;
        if (start && (!m_active || m_edge >= m_done_e + 2)) begin
          m_active = 1'b1;
          m_acc_e  = m_edge;
          m_accepts++;
          if (divisor == 0) begin
            m_done_e = m_edge;
            m_pq     = '1;
            m_pr     = dividend;
            m_pdbz   = 1'b1;
          end else begin
            m_done_e = m_edge + W;
            m_pq     = dividend / divisor;
            m_pr     = dividend % divisor;
            m_pdbz   = 1'b0;
          end
        end
        if (m_active && m_edge == m_done_e) begin
          e_q   = m_pq;
          e_r   = m_pr;
          e_dbz = m_pdbz;
          m_exp_dones++;
        end
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic e_busy, e_done;
    e_busy = m_active && (m_edge >= m_acc_e) && (m_edge <= m_done_e);
    e_done = m_active && (m_edge == m_done_e);
    if (done === 1'b1) seen_dones++;
    chk("busy", 32'(busy), 32'(e_busy));
    chk("done", 32'(done), 32'(e_done));
    chk("quotient", 32'(quotient), 32'(e_q));
    chk("remainder", 32'(remainder), 32'(e_r));
    chk("div_by_zero", 32'(div_by_zero), 32'(e_dbz));
  end

  // Wait (bounded) for done after the start edge; returns cycles after edge N.
  task automatic wait_done(output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
      else lat++;
    end
    if (!got) lat = -1;
  endtask

  task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv,
                        input logic [W-1:0] xq, input logic [W-1:0] xr,
                        input logic xdbz, input int xlat, input string tag);
    int lat;
    @(posedge clk);
    #2 start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk);
    #2 start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    wait_done(lat);
    chk({tag, " latency"}, 32'(lat), 32'(xlat));
    chk({tag, " q"}, 32'(quotient), 32'(xq));
    chk({tag, " r"}, 32'(remainder), 32'(xr));
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(xdbz));
    @(negedge clk);
    chk({tag, " busy low"}, 32'(busy), 32'(0));
  endtask

  initial begin
    int lat;
    int d0;
    int base;
    int budget;
    int r;
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset q", 32'(quotient), 32'(0));
    #2 rst = 1'b0;

    run_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 8, "100/7");
    run_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 8, "255/1");
    run_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 8, "255/255");
    run_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 8, "5/9");
    run_op(8'd200, 8'd0, 8'd255, 8'd200, 1'b1, 0, "200/0");
    run_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0, 8, "9/3");

    // Start ignored while busy.
    d0 = seen_dones;
    @(posedge clk);
    #2 start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 start = 1'b1; dividend = 8'd99; divisor = 8'd2;
    @(posedge clk);
    #2 start = 1'b0;
    wait_done(lat);
    chk("50/5 latency", 32'(lat), 32'(5));
    chk("50/5 q", 32'(quotient), 32'(10));
    chk("50/5 r", 32'(remainder), 32'(0));
    repeat (12) @(negedge clk);
    chk("50/5 one done", 32'(seen_dones - d0), 32'(1));

    // Reset mid-run aborts with no done.
    @(posedge clk);
    #2 start = 1'b1; dividend = 8'd77; divisor = 8'd4;
    @(posedge clk);
    #2 start = 1'b0;
    repeat (4) @(posedge clk);
    d0 = seen_dones;
    #2 rst = 1'b1;
    #1;
    chk("abort busy", 32'(busy), 32'(0));
    chk("abort done", 32'(done), 32'(0));
    chk("abort q", 32'(quotient), 32'(0));
    chk("abort r", 32'(remainder), 32'(0));
    chk("abort dbz", 32'(div_by_zero), 32'(0));
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort no done", 32'(seen_dones - d0), 32'(0));
    run_op(8'd77, 8'd4, 8'd19, 8'd1, 1'b0, 8, "77/4");

    // Random sweep: start pulses land anywhere, including while busy.
    base = m_accepts;
    budget = 0;
    while (m_accepts - base < 1000 && budget < 40000) begin
      @(posedge clk);
      #2;
      start = ($urandom % 4) != 0;
      dividend = W'($urandom);
      r = $urandom % 8;
      if (r == 0) divisor = '0;
      else if (r == 1) divisor = W'($urandom_range(1, 3));
      else divisor = W'($urandom);
      budget++;
    end
    start = 1'b0;
    chk("random sweep accepts", 32'(m_accepts - base >= 1000), 32'(1));
    repeat (12) @(negedge clk);
    chk("done count", 32'(seen_dones), 32'(m_exp_dones));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
